// File: rtl/riscv_multicycle_controller.sv
// Main control FSM for the multicycle RV32I-subset core, with the ALU and
// immediate-format decoders that steer the shared ALU and memory port.
module riscv_multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ImmSrc,
    output logic               RegWrite,
    output logic [2:0]         ALUControl,
    output logic [STATE_W-1:0] state
);

    localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXECUTER = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_EXECUTEI = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(10);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic [STATE_W-1:0] state_reg;
    logic [STATE_W-1:0] state_next;
    logic [1:0]         alu_op;
    logic               pc_update;
    logic               branch;
    logic               ir_write_raw;
    logic               reg_write_raw;
    logic               mem_write_raw;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_ITYPE:     state_next = S_EXECUTEI;
                    OP_JAL:       state_next = S_JAL;
                    OP_BEQ:       state_next = S_BEQ;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:   state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_next = S_MEMWB;
            S_MEMWB:    state_next = S_FETCH;
            S_MEMWRITE: state_next = S_FETCH;
            S_EXECUTER: state_next = S_ALUWB;
            S_EXECUTEI: state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_JAL:      state_next = S_ALUWB;
            S_BEQ:      state_next = S_FETCH;
            default:    state_next = S_FETCH;
        endcase
    end

    // Moore outputs; unused codes fall through to the all-zero defaults
    always_comb begin
        AdrSrc        = 1'b0;
        ResultSrc     = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        alu_op        = 2'b00;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        case (state_reg)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                pc_update    = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc     = 2'b01;
                reg_write_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_write_raw = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                alu_op  = 2'b10;
            end
            S_ALUWB: begin
                reg_write_raw = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA = 2'b10;
                alu_op  = 2'b01;
                branch  = 1'b1;
            end
            default: ;
        endcase
    end

    // Strobes are gated by reset so nothing is written while it is held
    assign PCWrite  = ~reset & (pc_update | (branch & Zero));
    assign IRWrite  = ~reset & ir_write_raw;
    assign RegWrite = ~reset & reg_write_raw;
    assign MemWrite = ~reset & mem_write_raw;
    assign state    = state_reg;

    always_comb begin
        ALUControl = 3'b000;
        case (alu_op)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// Self-checking bench: a directed instruction list followed by random
// instructions, each cycle compared against a per-instruction phase model.
module tb_riscv_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] state;

    riscv_multicycle_controller #(.STATE_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .ALUControl(ALUControl), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        z;
        int          len;
        logic [23:0] tr;
        int          alu2;
        int          pcw2;
        int          rst_step;
    } dir_t;

    localparam int N_DIR  = 12;
    localparam int N_RAND = 300;

    dir_t        d [N_DIR];
    int          total = 0;
    int          bad   = 0;
    int          di    = 0;
    int          n_done = 0;
    int          step  = 0;
    int          seq [$];
    logic [23:0] trace;
    int          alu2_act, pcw2_act;
    bit          inject;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t: got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Phase list of one instruction, as spec state codes, from FETCH up to its last cycle
    function automatic void build_seq(input logic [6:0] o);
        seq.delete();
        seq.push_back(0);
        seq.push_back(1);
        case (o)
            7'b0000011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            7'b0100011: begin seq.push_back(2); seq.push_back(5); end
            7'b0110011: begin seq.push_back(6); seq.push_back(7); end
            7'b0010011: begin seq.push_back(8); seq.push_back(7); end
            7'b1101111: begin seq.push_back(9); seq.push_back(7); end
            7'b1100011: seq.push_back(10);
            default: ;
        endcase
    endfunction

    function automatic logic [1:0] imm_model(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_model(input int ph);
        if (ph == 10) return 3'b001;
        if (ph == 6 || ph == 8) begin
            case (funct3)
                3'b000:  return (op[5] && funct7b5) ? 3'b001 : 3'b000;
                3'b010:  return 3'b101;
                3'b110:  return 3'b011;
                3'b111:  return 3'b010;
                default: return 3'b000;
            endcase
        end
        return 3'b000;
    endfunction

    function automatic bit is_supported(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1101111 || o == 7'b1100011;
    endfunction

    task automatic start_instr();
        logic [6:0] o;
        if (di < N_DIR) begin
            op = d[di].op; funct3 = d[di].f3; funct7b5 = d[di].f7;
        end else begin
            case ($urandom_range(0, 6))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1101111;
                5: o = 7'b1100011;
                default: begin
                    o = 7'($urandom);
                    while (is_supported(o)) o = 7'($urandom);
                end
            endcase
            op = o; funct3 = 3'($urandom); funct7b5 = 1'($urandom);
        end
        build_seq(op);
        step = 0;
        trace = '0;
        alu2_act = -1;
        pcw2_act = -1;
    endtask

    task automatic finish_instr();
        if (di < N_DIR && d[di].len >= 0) begin
            chk($sformatf("dir%0d_len", di), seq.size(), d[di].len);
            chk($sformatf("dir%0d_trace", di), trace, d[di].tr);
            if (d[di].alu2 >= 0) chk($sformatf("dir%0d_alu2", di), alu2_act, d[di].alu2);
            if (d[di].pcw2 >= 0) chk($sformatf("dir%0d_pcw2", di), pcw2_act, d[di].pcw2);
        end
        n_done++;
        di++;
    endtask

    task automatic set_zero();
        Zero = (di < N_DIR) ? d[di].z : 1'($urandom);
    endtask

    // Compare every output against the phase the model says this cycle is in
    task automatic check_cycle();
        int ph;
        logic pcw, adr, mw, irw, rw;
        logic [1:0] rs, a, b;
        ph = seq[step];
        pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; rs = 0; a = 0; b = 0;
        case (ph)
            0:  begin pcw = 1; irw = 1; b = 2'b10; rs = 2'b10; end
            1:  begin a = 2'b01; b = 2'b01; end
            2:  begin a = 2'b10; b = 2'b01; end
            3:  adr = 1;
            4:  begin rs = 2'b01; rw = 1; end
            5:  begin adr = 1; mw = 1; end
            6:  a = 2'b10;
            7:  rw = 1;
            8:  begin a = 2'b10; b = 2'b01; end
            9:  begin a = 2'b01; b = 2'b10; pcw = 1; end
            10: begin a = 2'b10; pcw = Zero; end
            default: ;
        endcase
        chk("state",      state,      ph);
        chk("PCWrite",    PCWrite,    pcw);
        chk("AdrSrc",     AdrSrc,     adr);
        chk("MemWrite",   MemWrite,   mw);
        chk("IRWrite",    IRWrite,    irw);
        chk("RegWrite",   RegWrite,   rw);
        chk("ResultSrc",  ResultSrc,  rs);
        chk("ALUSrcA",    ALUSrcA,    a);
        chk("ALUSrcB",    ALUSrcB,    b);
        chk("ImmSrc",     ImmSrc,     imm_model(op));
        chk("ALUControl", ALUControl, alu_model(ph));
        trace = (trace << 4) | 24'(state);
        if (step == 2) begin
            alu2_act = int'(ALUControl);
            pcw2_act = int'(PCWrite);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"},    state,    0);
        chk({tag, "_PCWrite"},  PCWrite,  0);
        chk({tag, "_IRWrite"},  IRWrite,  0);
        chk({tag, "_RegWrite"}, RegWrite, 0);
        chk({tag, "_MemWrite"}, MemWrite, 0);
    endtask

    initial begin
        d[0]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, 5, 24'h01234, 0, 0, -1};
        d[1]  = '{7'b0100011, 3'b010, 1'b0, 1'b0, 4, 24'h00125, 0, 0, -1};
        d[2]  = '{7'b0110011, 3'b000, 1'b1, 1'b0, 4, 24'h00167, 1, 0, -1};
        d[3]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, 4, 24'h00167, 2, 0, -1};
        d[4]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, 4, 24'h00167, 3, 0, -1};
        d[5]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, 4, 24'h00167, 5, 0, -1};
        d[6]  = '{7'b1100011, 3'b000, 1'b0, 1'b1, 3, 24'h0001A, 1, 1, -1};
        d[7]  = '{7'b1100011, 3'b000, 1'b0, 1'b0, 3, 24'h0001A, 1, 0, -1};
        d[8]  = '{7'b1101111, 3'b000, 1'b0, 1'b0, 4, 24'h00197, 0, 1, -1};
        d[9]  = '{7'b0000000, 3'b000, 1'b0, 1'b0, 2, 24'h00001, -1, -1, -1};
        d[10] = '{7'b0010011, 3'b000, 1'b1, 1'b0, 4, 24'h00187, 0, 0, -1};
        d[11] = '{7'b0100011, 3'b000, 1'b0, 1'b0, -1, 24'h0, -1, -1, 3};

        reset = 1'b1;
        Zero  = 1'b0;
        start_instr();
        #10;
        check_reset("por");
        #12;
        reset = 1'b0;
        set_zero();
        #1;
        chk("fetch_PCWrite", PCWrite, 1);
        chk("fetch_IRWrite", IRWrite, 1);
        chk("fetch_ALUSrcB", ALUSrcB, 2'b10);
        check_cycle();
        step = 1;

        while (n_done < N_DIR + N_RAND) begin
            @(negedge clk);
            if (step == seq.size()) begin
                finish_instr();
                if (n_done >= N_DIR + N_RAND) break;
                start_instr();
            end
            set_zero();
            #1;
            check_cycle();
            inject = (di < N_DIR) ? (d[di].rst_step == step)
                                  : (step >= 1 && $urandom_range(0, 24) == 0);
            step++;
            if (inject) begin
                #1 reset = 1'b1;
                #1 check_reset("rst_mid");
                @(negedge clk);
                #1 check_reset("rst_hold");
                reset = 1'b0;
                n_done++;
                di++;
                if (n_done >= N_DIR + N_RAND) break;
                start_instr();
                set_zero();
                #1;
                check_cycle();
                step = 1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
